p4_router_tbl_cfg_initiator: RTL and testbench

AXI4-Lite initiator (master) that drives the per-queue policer and congestion-management table configuration slaves of the queue system.
Accepts single read/write commands on a simple valid/ready command port and runs one complete AXI4-Lite transaction per command.
Returns read data and response status on a response port.
Sits between the core-clock side of the router register block and the queue system's table config interfaces; one instance per table.

---
 rtl/p4_router_tbl_cfg_initiator.sv | 213 +++++++++++++++++++++
 tb/tb_p4_router_tbl_cfg_initiator.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_router_tbl_cfg_initiator.sv
// rtl/p4_router_tbl_cfg_initiator.sv - AXI4-Lite initiator for per-queue table configuration
//
// Runs one complete AXI4-Lite transaction per accepted command and returns a
// single-cycle response. One instance per queue-system table.
//
// Ports:
//   clk, sresetn            core clock, asynchronous active-low reset
//   cmd_*                   command port (valid/ready, write flag, addr, wdata)
//   rsp_*                   response pulse, read data (0 for writes), error flag
//   busy                    transaction in flight
//   aw*/w*/b*/ar*/r*        AXI4-Lite initiator channels
//   timeout_seen            sticky timeout flag (only with P4_ROUTER_TBL_CFG_TIMEOUT_EN)
//
// Optional feature: define P4_ROUTER_TBL_CFG_TIMEOUT_EN to abort a transaction
// whose slave handshake is absent for TIMEOUT_CYCLES cycles.

module p4_router_tbl_cfg_initiator #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    sresetn,
`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
   output logic                    timeout_seen,
`endif
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    busy,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready
);

   if (TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      WR_B = 3'd2,
      RD_A = 3'd3,
      RD_D = 3'd4
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;

   // A channel is finished inside WR once its valid has been dropped, or
   // when the handshake completes on this edge.
   logic aw_fin;
   logic w_fin;

   assign aw_fin = !awvalid || awready;
   assign w_fin  = !wvalid  || wready;

   // Address and data come straight from the command capture registers, which
   // only change on accept, so they are stable while any valid is high.
   assign awaddr = addr_q;
   assign araddr = addr_q;
   assign wdata  = wdata_q;
   assign wstrb  = wvalid ? '1 : '0;
   assign busy   = (state != IDLE);

`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_cnt;
   logic          wait_done;

   // The handshake the current state is waiting on has arrived this cycle.
   always_comb begin
      wait_done = 1'b1;
      case (state)
         WR:      wait_done = aw_fin && w_fin;
         WR_B:    wait_done = bvalid;
         RD_A:    wait_done = arready;
         RD_D:    wait_done = rvalid;
         default: wait_done = 1'b1;
      endcase
   end
`endif

   always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
         tmo_cnt      <= '0;
         timeout_seen <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               // cmd_ready stays low through the response cycle, so a new
               // command can never be taken while rsp_valid is high.
               if (rsp_valid) begin
                  cmd_ready <= 1'b1;
               end else if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  addr_q    <= cmd_addr;
                  wdata_q   <= cmd_wdata;
`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
                  if (cmd_write) begin
                     state   <= WR;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                  end else begin
                     state   <= RD_A;
                     arvalid <= 1'b1;
                  end
               end
            end
            WR: begin
               if (awvalid && awready) awvalid <= 1'b0;
               if (wvalid && wready)   wvalid  <= 1'b0;
               if (aw_fin && w_fin) begin
                  state  <= WR_B;
                  bready <= 1'b1;
`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end
            end
            WR_B: begin
               if (bvalid) begin
                  bready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= (bresp != 2'b00);
                  rsp_rdata <= '0;
                  state     <= IDLE;
               end
            end
            RD_A: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RD_D;
`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end
            end
            RD_D: begin
               if (rvalid) begin
                  rready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= (rresp != 2'b00);
                  rsp_rdata <= rdata;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
         // Placed after the case so an abort overrides any state update.
         if (state != IDLE && !wait_done) begin
            if (tmo_cnt == TMO_LAST) begin
               awvalid      <= 1'b0;
               wvalid       <= 1'b0;
               bready       <= 1'b0;
               arvalid      <= 1'b0;
               rready       <= 1'b0;
               rsp_valid    <= 1'b1;
               rsp_err      <= 1'b1;
               rsp_rdata    <= '0;
               timeout_seen <= 1'b1;
               state        <= IDLE;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_p4_router_tbl_cfg_initiator.sv
// tb/tb_p4_router_tbl_cfg_initiator.sv - self-checking bench for p4_router_tbl_cfg_initiator

module tb_p4_router_tbl_cfg_initiator;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          sresetn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_err, busy;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
   logic          timeout_seen;
`endif

   always #5 clk = ~clk;

   p4_router_tbl_cfg_initiator #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .sresetn(sresetn),
`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
      .timeout_seen(timeout_seen),
`endif
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          aw_d, w_d, b_d, ar_d, r_d;
      logic [1:0]  bresp, rresp;
      bit          early;
      bit          tmo;
      bit          exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   // Slave configuration and observed traffic
   int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
   logic [1:0]  bresp_cfg = 0, rresp_cfg = 0;
   bit          early = 0;
   logic [31:0] smem [256];
   logic [31:0] model_mem [256];
   int          aw_beats = 0, w_beats = 0, ar_beats = 0;
   logic [7:0]  got_awaddr, got_araddr;
   logic [31:0] got_wdata;
   logic [3:0]  got_wstrb;
   bit          split_seen = 0;

   // Slave internal state
   bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [7:0]  awaddr_s, araddr_s;
   logic [31:0] wdata_s;
   logic [3:0]  wstrb_s;
   bit          aw_got, w_got, b_pend, ar_got;
   int          aw_w, w_w, b_w, ar_w, r_w;

   // Behavioural AXI4-Lite slave with programmable wait states
   initial begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
      aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
      forever begin
         @(negedge clk);
         aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
         ar_hs = arvalid && arready; r_hs = rvalid && rready;
         awaddr_s = awaddr; araddr_s = araddr; wdata_s = wdata; wstrb_s = wstrb;
         @(posedge clk); #1;
         if (!sresetn) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
            aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
            continue;
         end
         if (aw_hs) begin
            aw_got = 1; awready = 0; aw_w = 0; aw_beats++; got_awaddr = awaddr_s;
         end else if (awvalid && !awready) begin
            if (aw_w >= aw_d) awready = 1; else aw_w++;
         end else if (!awvalid) aw_w = 0;
         if (w_hs) begin
            w_got = 1; wready = 0; w_w = 0; w_beats++; got_wdata = wdata_s; got_wstrb = wstrb_s;
         end else if (wvalid && !wready) begin
            if (w_w >= w_d) wready = 1; else w_w++;
         end else if (!wvalid) w_w = 0;
         if (b_hs) begin
            bvalid = 0; aw_got = 0; w_got = 0; b_pend = 0; b_w = 0;
         end else begin
            if (aw_got && w_got && !b_pend) begin
               b_pend = 1; smem[got_awaddr] = got_wdata;
            end
            if (!bvalid && ((b_pend && b_w >= b_d) || (early && (awvalid || wvalid)))) begin
               bvalid = 1; bresp = bresp_cfg;
            end else if (b_pend && !bvalid) b_w++;
         end
         if (ar_hs) begin
            ar_got = 1; arready = 0; ar_w = 0; ar_beats++; got_araddr = araddr_s;
         end else if (arvalid && !arready) begin
            if (ar_w >= ar_d) arready = 1; else ar_w++;
         end else if (!arvalid) ar_w = 0;
         if (r_hs) begin
            rvalid = 0; ar_got = 0; r_w = 0;
         end else if (!rvalid && ((ar_got && r_w >= r_d) || (early && arvalid))) begin
            rvalid = 1; rdata = smem[ar_got ? got_araddr : araddr]; rresp = rresp_cfg;
         end else if (ar_got && !rvalid) r_w++;
      end
   end

   // Protocol monitor: valids held until ready, payload stable, wstrb, cmd_ready gating
   bit         p_aw = 0, p_w = 0, p_ar = 0;
   logic [7:0] p_awa, p_ara;
   logic [31:0] p_wd;
   initial begin
      forever begin
         @(negedge clk);
         if (!sresetn) begin
            p_aw = 0; p_w = 0; p_ar = 0;
            continue;
         end
         if (p_aw) begin
            chk("awvalid_held", awvalid || rsp_valid, 1);
            if (awvalid) chk("awaddr_stable", awaddr, p_awa);
         end
         if (p_w) begin
            chk("wvalid_held", wvalid || rsp_valid, 1);
            if (wvalid) chk("wdata_stable", wdata, p_wd);
         end
         if (p_ar) begin
            chk("arvalid_held", arvalid || rsp_valid, 1);
            if (arvalid) chk("araddr_stable", araddr, p_ara);
         end
         if (wvalid) chk("wstrb_ones", wstrb, 4'hF);
         if (busy) chk("cmd_ready_when_busy", cmd_ready, 0);
         if (busy && awvalid && !wvalid) split_seen = 1;
         p_aw = awvalid && !awready; p_awa = awaddr;
         p_w  = wvalid && !wready;   p_wd  = wdata;
         p_ar = arvalid && !arready; p_ara = araddr;
      end
   end

   function automatic vec_t mk(bit wr, logic [7:0] a, logic [31:0] d, int awd, int wd, int bd,
                               int ard, int rd, logic [1:0] br, logic [1:0] rr, bit e,
                               bit err, logic [31:0] rdat, int lat);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.aw_d = awd; v.w_d = wd; v.b_d = bd;
      v.ar_d = ard; v.r_d = rd; v.bresp = br; v.rresp = rr; v.early = e; v.tmo = 0;
      v.exp_err = err; v.exp_rdata = rdat; v.exp_lat = lat;
      return v;
   endfunction

   // Reference: response from the table contents and slave status, latency as
   // 3 cycles plus the slave wait states that are actually on the critical path.
   function automatic vec_t predict(input vec_t v);
      vec_t r = v;
      if (v.wr) begin
         r.exp_err   = (v.bresp != 0);
         r.exp_rdata = 0;
         r.exp_lat   = 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + (v.early ? 0 : v.b_d);
      end else begin
         r.exp_err   = (v.rresp != 0);
         r.exp_rdata = model_mem[v.addr];
         r.exp_lat   = 3 + v.ar_d + (v.early ? 0 : v.r_d);
      end
      return r;
   endfunction

   task automatic run_cmd(input vec_t v);
      int n, acc, lat, awb, wb, arb;
      @(negedge clk);
      aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d; ar_d = v.ar_d; r_d = v.r_d;
      bresp_cfg = v.bresp; rresp_cfg = v.rresp; early = v.early;
      cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      chk("cmd_accept", cmd_ready, 1);
      acc = cyc; awb = aw_beats; wb = w_beats; arb = ar_beats;
      @(negedge clk);
      cmd_valid = 0;
      n = 0;
      while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
      chk("rsp_seen", rsp_valid, 1);
      lat = cyc - acc;
      chk("rsp_latency", lat, v.exp_lat);
      chk("rsp_err", rsp_err, v.exp_err);
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("idle_at_rsp", {cmd_ready, busy, awvalid, wvalid, bready, arvalid, rready}, 0);
      if (v.tmo) begin
         chk("ar_beats_tmo", ar_beats - arb, 0);
      end else if (v.wr) begin
         chk("aw_beats", aw_beats - awb, 1);
         chk("w_beats", w_beats - wb, 1);
         chk("awaddr", got_awaddr, v.addr);
         chk("wdata", got_wdata, v.wdata);
         chk("wstrb", got_wstrb, 4'hF);
         model_mem[v.addr] = v.wdata;
      end else begin
         chk("ar_beats", ar_beats - arb, 1);
         chk("araddr", got_araddr, v.addr);
      end
   endtask

   vec_t tbl [7];
   vec_t v;
   int   n, r1, acc1, acc2;

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      for (int i = 0; i < 256; i++) begin smem[i] = 0; model_mem[i] = 0; end
      sresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {cmd_ready, rsp_valid, rsp_err, busy, awvalid, wvalid,
                            bready, arvalid, rready}, 9'b1_0000_0000);
      chk("reset_rdata", rsp_rdata, 0);
      sresetn = 1;
      @(negedge clk);
      chk("post_reset_ready", cmd_ready, 1);

      //        wr addr   wdata         aw w  b  ar r  br     rr     e  err rdata         lat
      tbl[0] = mk(1, 8'h05, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0,         3);
      tbl[1] = mk(1, 8'h12, 32'h0000ABCD, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0,         3);
      tbl[2] = mk(0, 8'h12, 32'h0,        0, 0, 0, 4, 2, 2'b00, 2'b00, 0, 0, 32'h0000ABCD,  9);
      tbl[3] = mk(1, 8'h20, 32'h12345678, 5, 0, 0, 0, 0, 2'b10, 2'b00, 0, 1, 32'h0,         8);
      tbl[4] = mk(0, 8'h05, 32'h0,        0, 0, 0, 0, 3, 2'b00, 2'b11, 1, 1, 32'hDEADBEEF,  3);
      tbl[5] = mk(1, 8'h07, 32'hCAFE0007, 2, 2, 1, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0,         6);
      tbl[6] = mk(0, 8'h20, 32'h0,        0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h12345678,  3);
      for (int i = 0; i < 7; i++) begin
         if (i == 3) split_seen = 0;
         run_cmd(tbl[i]);
         if (i == 3) chk("aw_w_split", split_seen, 1);
      end

      // Back-to-back with cmd_valid held high
      @(negedge clk);
      aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; bresp_cfg = 0; rresp_cfg = 0; early = 0;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h08; cmd_wdata = 32'h0BADF00D;
      chk("b2b_first_ready", cmd_ready, 1);
      acc1 = cyc;
      @(negedge clk);
      cmd_write = 0;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      r1 = cyc;
      chk("b2b_rsp1_lat", r1 - acc1, 3);
      chk("b2b_rsp1_ready_low", cmd_ready, 0);
      @(negedge clk);
      chk("b2b_second_accept", cmd_ready && cmd_valid, 1);
      acc2 = cyc;
      model_mem[8'h08] = 32'h0BADF00D;
      @(negedge clk);
      cmd_valid = 0;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      chk("b2b_rsp2_lat", cyc - acc2, 3);
      chk("b2b_rsp2_rdata", rsp_rdata, 32'h0BADF00D);
      repeat (2) @(negedge clk);
      chk("rdata_hold", {rsp_valid, rsp_rdata}, {1'b0, 32'h0BADF00D});

      // Reset while waiting in WR_B
      @(negedge clk);
      b_d = 10;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h30; cmd_wdata = 32'hAAAA5555;
      @(negedge clk);
      cmd_valid = 0;
      n = 0;
      while (!bready && n < 20) begin @(negedge clk); n++; end
      chk("reached_wr_b", bready, 1);
      model_mem[8'h30] = 32'hAAAA5555;
      #2 sresetn = 0;
      #1 chk("async_abort", {awvalid, wvalid, bready, arvalid, rready, busy, rsp_valid}, 0);
      chk("ready_in_reset", cmd_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_rsp_in_reset", rsp_valid, 0);
      end
      sresetn = 1;
      b_d = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("after_reset_idle", {cmd_ready, busy, rsp_valid}, 3'b100);
      end

`ifdef P4_ROUTER_TBL_CFG_TIMEOUT_EN
      chk("timeout_seen_clear", timeout_seen, 0);
      v = mk(0, 8'h05, 32'h0, 0, 0, 0, 100000, 0, 2'b00, 2'b00, 0, 1, 32'h0, 17);
      v.tmo = 1;
      run_cmd(v);
      chk("timeout_seen_set", timeout_seen, 1);
`endif

      // Randomized traffic against the reference model
      for (int i = 0; i < 24; i++) begin
         v.wr    = $urandom_range(0, 1);
         v.addr  = 8'($urandom_range(0, 7));
         v.wdata = $urandom;
         v.aw_d  = $urandom_range(0, 3);
         v.w_d   = $urandom_range(0, 3);
         v.b_d   = $urandom_range(0, 3);
         v.ar_d  = $urandom_range(0, 3);
         v.r_d   = $urandom_range(0, 3);
         v.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         v.rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         v.early = ($urandom_range(0, 4) == 0);
         v.tmo   = 0;
         v = predict(v);
         run_cmd(v);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
